// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit arbiter: packet command codes,
// arbiter state encoding and the maximum data payload size.
package usb_pkg;

    typedef enum logic [1:0] {
        PKT_NONE = 2'd0,
        PKT_DATA = 2'd1,
        PKT_ACK  = 2'd2,
        PKT_NAK  = 2'd3
    } tx_pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP
    } arb_state_t;

    localparam int MAX_PAYLOAD = 64;
    localparam int SIZE_W      = 7;

    function automatic logic [SIZE_W-1:0] sat_size(input logic [SIZE_W-1:0] sz);
        return (sz > SIZE_W'(MAX_PAYLOAD)) ? SIZE_W'(MAX_PAYLOAD) : sz;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter that wraps to zero after rollover_val enabled clocks;
// rollover_flag marks the last counted clock of each period.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] r_count;

    assign rollover_flag = count_enable && (r_count == rollover_val - WIDTH'(1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear || rollover_flag) begin
            r_count <= '0;
        end else if (count_enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/usb_tx_arb.sv
// Arbitrates handshake and data packet requests onto one USB transmitter.
// Define USB_TX_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog and a timeout output.
module usb_tx_arb
    import usb_pkg::*;
#(
    parameter int IPG_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic       hs_nak,
    output logic       hs_done,
    input  logic       data_req,
    input  logic [6:0] data_size,
    output logic       data_done,
    output logic       data_pop,
    output logic [1:0] tx_packet,
    output logic [6:0] tx_packet_data_size,
    input  logic       tx_get_packet,
    input  logic       tx_done,
`ifdef USB_TX_ARB_TIMEOUT_EN
    output logic       timeout,
`endif
    output logic       busy
);

    localparam int CNT_MAX = (IPG_CYCLES > TIMEOUT_CYCLES) ? IPG_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_t r_state;
    arb_state_t w_state_next;

    logic             r_grant_data;
    logic             r_nak;
    logic [6:0]       r_size;
    logic             r_hs_done;
    logic             r_data_done;
    logic             w_cnt_clear;
    logic             w_cnt_en;
    logic             w_cnt_roll;
    logic [CNT_W-1:0] w_cnt_rollover;
    logic             w_finish;
    logic             w_expired;
    logic             w_in_packet;
    logic             w_any_req;

    assign w_any_req = hs_req || data_req;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_en       = 1'b0;
        w_cnt_rollover = CNT_W'(IPG_CYCLES);
        w_expired      = 1'b0;
        w_finish       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
`ifdef USB_TX_ARB_TIMEOUT_EN
                w_cnt_en       = 1'b1;
                w_cnt_rollover = CNT_W'(TIMEOUT_CYCLES);
                w_expired      = w_cnt_roll && !tx_done;
`endif
                w_finish = tx_done || w_expired;
                if (w_finish) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                w_cnt_en = 1'b1;
                if (w_cnt_roll) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Every state change restarts the shared counter, so GAP and the
    // watchdog each begin counting from zero.
    assign w_cnt_clear = (w_state_next != r_state);

    flex_counter #(
        .WIDTH(CNT_W)
    ) u_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (w_cnt_clear),
        .count_enable (w_cnt_en),
        .rollover_val (w_cnt_rollover),
        .rollover_flag(w_cnt_roll)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_grant_data <= 1'b0;
            r_nak        <= 1'b0;
            r_size       <= '0;
            r_hs_done    <= 1'b0;
            r_data_done  <= 1'b0;
        end else begin
            r_hs_done   <= 1'b0;
            r_data_done <= 1'b0;
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant_data <= !hs_req;
                r_nak        <= hs_nak;
                r_size       <= sat_size(data_size);
            end
            if (r_state == ST_WAIT_DONE && w_finish) begin
                r_hs_done   <= !r_grant_data;
                r_data_done <= r_grant_data;
            end
        end
    end

`ifdef USB_TX_ARB_TIMEOUT_EN
    logic r_timeout;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (r_state == ST_WAIT_DONE) && w_expired;
        end
    end

    assign timeout = r_timeout;
`endif

    assign w_in_packet = (r_state == ST_ISSUE) || (r_state == ST_WAIT_DONE);

    always_comb begin
        tx_packet = PKT_NONE;
        if (r_state == ST_ISSUE) begin
            if (r_grant_data) begin
                tx_packet = PKT_DATA;
            end else if (r_nak) begin
                tx_packet = PKT_NAK;
            end else begin
                tx_packet = PKT_ACK;
            end
        end
    end

    assign tx_packet_data_size = (w_in_packet && r_grant_data) ? r_size : 7'd0;
    assign data_pop            = w_in_packet && r_grant_data && tx_get_packet;
    assign busy                = (r_state != ST_IDLE);
    assign hs_done             = r_hs_done;
    assign data_done           = r_data_done;

endmodule

// File: tb/tb_usb_tx_arb.sv
// Scoreboard bench for usb_tx_arb: stimulus queues expected observations,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_usb_tx_arb;

    localparam int IPG = 16;
    localparam int TMO = 100;

    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_DATA = 2'd1;
    localparam logic [1:0] P_ACK  = 2'd2;
    localparam logic [1:0] P_NAK  = 2'd3;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       hs_req = 1'b0;
    logic       hs_nak = 1'b0;
    logic       data_req = 1'b0;
    logic [6:0] data_size = 7'd0;
    logic       tx_get_packet = 1'b0;
    logic       tx_done = 1'b0;
    logic       hs_done;
    logic       data_done;
    logic       data_pop;
    logic [1:0] tx_packet;
    logic [6:0] tx_packet_data_size;
    logic       busy;
    logic       w_tmo;

    usb_tx_arb #(
        .IPG_CYCLES    (IPG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .hs_req             (hs_req),
        .hs_nak             (hs_nak),
        .hs_done            (hs_done),
        .data_req           (data_req),
        .data_size          (data_size),
        .data_done          (data_done),
        .data_pop           (data_pop),
        .tx_packet          (tx_packet),
        .tx_packet_data_size(tx_packet_data_size),
        .tx_get_packet      (tx_get_packet),
        .tx_done            (tx_done),
`ifdef USB_TX_ARB_TIMEOUT_EN
        .timeout            (w_tmo),
`endif
        .busy               (busy)
    );

`ifndef USB_TX_ARB_TIMEOUT_EN
    assign w_tmo = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] code;
        logic [6:0] size;
        logic       hd;
        logic       dd;
        logic       pop;
        logic       tmo;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    task automatic push_ev(input logic [1:0] code, input logic [6:0] size, input logic hd,
                           input logic dd, input logic pop, input logic tmo, input int at);
        ev_t e;
        e.code = code;
        e.size = size;
        e.hd   = hd;
        e.dd   = dd;
        e.pop  = pop;
        e.tmo  = tmo;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d want %0d (cyc=%0d)", name, act, req, cyc);
        end else begin
            $display("chk %s = %0d ok (cyc=%0d)", name, act, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (n_rst && (tx_packet != P_NONE || hs_done || data_done || data_pop || w_tmo)) begin
            checks++;
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                failures++;
                $display("FAIL missed_event: got nothing want pkt=%0d pop=%0d hd=%0d dd=%0d at cyc=%0d",
                         e.code, e.pop, e.hd, e.dd, e.at);
            end
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output cyc=%0d: got pkt=%0d size=%0d hd=%0d dd=%0d pop=%0d tmo=%0d want none",
                         cyc, tx_packet, tx_packet_data_size, hs_done, data_done, data_pop, w_tmo);
            end else begin
                e = exp_q.pop_front();
                if (e.at !== cyc || e.code !== tx_packet || e.size !== tx_packet_data_size ||
                    e.hd !== hs_done || e.dd !== data_done || e.pop !== data_pop || e.tmo !== w_tmo) begin
                    failures++;
                    $display("FAIL txn: got cyc=%0d pkt=%0d size=%0d hd=%0d dd=%0d pop=%0d tmo=%0d want cyc=%0d pkt=%0d size=%0d hd=%0d dd=%0d pop=%0d tmo=%0d",
                             cyc, tx_packet, tx_packet_data_size, hs_done, data_done, data_pop, w_tmo,
                             e.at, e.code, e.size, e.hd, e.dd, e.pop, e.tmo);
                end else begin
                    $display("txn cyc=%0d pkt=%0d size=%0d hd=%0d dd=%0d pop=%0d tmo=%0d ok",
                             cyc, tx_packet, tx_packet_data_size, hs_done, data_done, data_pop, w_tmo);
                end
            end
        end
    end

    initial begin
        int t;
        int d;

        // Reset state
        tick(3);
        check("rst_tx_packet", int'(tx_packet), 0);
        check("rst_size", int'(tx_packet_data_size), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dones", int'(hs_done) + int'(data_done) + int'(data_pop), 0);
        n_rst = 1'b1;
        tick(2);

        // ACK: issue one clock after request, done one clock after tx_done
        t = cyc;
        hs_req = 1'b1;
        hs_nak = 1'b0;
        push_ev(P_ACK, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, t + 1);
        tick(4);
        check("busy_wait_done", int'(busy), 1);
        tx_get_packet = 1'b1;
        tick(1);
        tx_get_packet = 1'b0;
        tick(3);
        tx_done = 1'b1;
        push_ev(P_NONE, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, cyc + 1);
        tick(1);
        tx_done = 1'b0;
        hs_req = 1'b0;
        tick(3);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(IPG);
        check("busy_idle", int'(busy), 0);

        // Simultaneous requests: NAK first, DATA IPG+2 clocks after hs tx_done
        t = cyc;
        hs_req = 1'b1;
        hs_nak = 1'b1;
        data_req = 1'b1;
        data_size = 7'd10;
        push_ev(P_NAK, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, t + 1);
        tick(3);
        tx_done = 1'b1;
        d = cyc;
        push_ev(P_NONE, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, d + 1);
        push_ev(P_DATA, 7'd10, 1'b0, 1'b0, 1'b0, 1'b0, d + IPG + 2);
        tick(1);
        tx_done = 1'b0;
        hs_req = 1'b0;
        tick(IPG + 3);
        tx_done = 1'b1;
        push_ev(P_NONE, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, cyc + 1);
        tick(1);
        tx_done = 1'b0;
        data_req = 1'b0;
        tick(IPG + 2);

        // Five-byte data packet, requester drops early
        t = cyc;
        data_req = 1'b1;
        data_size = 7'd5;
        push_ev(P_DATA, 7'd5, 1'b0, 1'b0, 1'b0, 1'b0, t + 1);
        tick(2);
        data_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_get_packet = 1'b1;
            push_ev(P_NONE, 7'd5, 1'b0, 1'b0, 1'b1, 1'b0, cyc);
            tick(1);
            tx_get_packet = 1'b0;
            tick(1);
        end
        tx_done = 1'b1;
        push_ev(P_NONE, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, cyc + 1);
        tick(1);
        tx_done = 1'b0;
        tick(IPG + 2);

        // Oversize payload saturates to 64
        t = cyc;
        data_req = 1'b1;
        data_size = 7'd100;
        push_ev(P_DATA, 7'd64, 1'b0, 1'b0, 1'b0, 1'b0, t + 1);
        tick(2);
        check("sat_size_wait", int'(tx_packet_data_size), 64);
        tx_get_packet = 1'b1;
        push_ev(P_NONE, 7'd64, 1'b0, 1'b0, 1'b1, 1'b0, cyc);
        tick(1);
        tx_get_packet = 1'b0;
        tx_done = 1'b1;
        push_ev(P_NONE, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, cyc + 1);
        tick(1);
        tx_done = 1'b0;
        data_req = 1'b0;
        tick(IPG + 2);

        // Reset during WAIT_DONE
        t = cyc;
        data_req = 1'b1;
        data_size = 7'd7;
        push_ev(P_DATA, 7'd7, 1'b0, 1'b0, 1'b0, 1'b0, t + 1);
        tick(3);
        check("pre_rst_size", int'(tx_packet_data_size), 7);
        n_rst = 1'b0;
        tx_get_packet = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_size", int'(tx_packet_data_size), 0);
        check("midrst_pop", int'(data_pop), 0);
        tx_get_packet = 1'b0;
        data_req = 1'b0;
        tx_done = 1'b1;
        tick(2);
        tx_done = 1'b0;
        n_rst = 1'b1;
        hs_req = 1'b1;
        hs_nak = 1'b1;
        push_ev(P_NAK, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, cyc + 1);
        tick(3);
        tx_done = 1'b1;
        push_ev(P_NONE, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, cyc + 1);
        tick(1);
        tx_done = 1'b0;
        hs_req = 1'b0;
        tick(IPG + 2);

`ifdef USB_TX_ARB_TIMEOUT_EN
        // Watchdog: no tx_done ends the packet with timeout + data_done
        t = cyc;
        data_req = 1'b1;
        data_size = 7'd3;
        push_ev(P_DATA, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0, t + 1);
        push_ev(P_NONE, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, t + TMO + 2);
        tick(2);
        data_req = 1'b0;
        tick(TMO + 3);
        check("tmo_in_gap_busy", int'(busy), 1);
        tick(IPG + 2);
        check("tmo_after_gap_idle", int'(busy), 0);
`else
        // Without the watchdog the packet waits indefinitely for tx_done
        t = cyc;
        data_req = 1'b1;
        data_size = 7'd3;
        push_ev(P_DATA, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0, t + 1);
        tick(2);
        data_req = 1'b0;
        tick(TMO + 20);
        check("no_tmo_still_busy", int'(busy), 1);
        tx_done = 1'b1;
        push_ev(P_NONE, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, cyc + 1);
        tick(1);
        tx_done = 1'b0;
        tick(IPG + 2);
`endif

        tick(5);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx_arb.md
USB_TX_ARB -- requirements
Module: usb_tx_arb

Interface
REQ-001 The block SHALL provide parameter IPG_CYCLES, default 16, minimum idle clocks between end of one packet and start of next.
REQ-002 The block SHALL provide parameter TIMEOUT_CYCLES, default 2048, maximum clocks from issue to tx_done before abort (used only under REQ-026).
REQ-003 The block SHALL have the following ports:
  - clk  in  1  system clock, rising edge
  - n_rst  in  1  asynchronous active-low reset
  - hs_req  in  1  handshake requester wants to send; held until hs_done
  - hs_nak  in  1  handshake type: 0=ACK, 1=NAK; sampled at grant
  - hs_done  out  1  one-cycle pulse: handshake packet finished
  - data_req  in  1  data requester wants to send; held until data_done
  - data_size  in  7  data payload byte count 0..64; sampled at grant
  - data_done  out  1  one-cycle pulse: data packet finished
  - data_pop  out  1  one-cycle pop to the data FIFO; mirrors tx_get_packet while data is granted
  - tx_packet  out  2  packet command to the USB transmitter
  - tx_packet_data_size  out  7  byte count to the transmitter
  - tx_get_packet  in  1  transmitter consumed one data byte
  - tx_done  in  1  transmitter finished current packet
  - busy  out  1  high in any state other than IDLE

Function
REQ-004 tx_packet encoding SHALL be 2'd0 NONE, 2'd1 DATA, 2'd2 ACK, 2'd3 NAK.
REQ-005 States SHALL be IDLE, ISSUE, WAIT_DONE, GAP.
REQ-006 In IDLE with any request, the block SHALL latch the grant (hs over data), hs_nak or data_size, and go to ISSUE next cycle.
REQ-007 Handshake SHALL have fixed priority over data; simultaneous hs_req and data_req SHALL grant hs.
REQ-008 In ISSUE, tx_packet SHALL carry the granted code for exactly one cycle; then WAIT_DONE. tx_packet SHALL be NONE in all other states.
REQ-009 tx_packet_data_size SHALL hold the latched data_size from ISSUE until leaving WAIT_DONE for a data grant, else 0.
REQ-010 data_pop SHALL equal tx_get_packet combinationally while data is granted and state is ISSUE or WAIT_DONE; else 0.
REQ-011 tx_get_packet during an hs grant SHALL be ignored.
REQ-012 tx_done in WAIT_DONE SHALL pulse the granted requester's done output the next cycle and move to GAP.
REQ-013 tx_done outside WAIT_DONE SHALL be ignored.
REQ-014 GAP SHALL last exactly IPG_CYCLES clocks, then IDLE; requests arriving during GAP SHALL wait.
REQ-015 Requester deassert before done SHALL NOT cancel an issued packet.
REQ-016 IDLE to ISSUE latency SHALL be 1 clock from request; issue-to-issue spacing SHALL be at least IPG_CYCLES+2.
REQ-017 data_size greater than 64 SHALL be saturated to 64 at latch.

Reset
REQ-018 On n_rst low, state SHALL be IDLE and all outputs 0, asynchronously.
REQ-019 Reset mid-packet SHALL drop the grant with no done pulse.
REQ-020 After reset release, first issue SHALL NOT require a GAP.

Configuration
REQ-021 Macro USB_TX_ARB_TIMEOUT_EN SHALL compile in a watchdog counter active in WAIT_DONE.
REQ-022 With it, reaching TIMEOUT_CYCLES without tx_done SHALL pulse the granted done output and go to GAP, and a status output timeout (1 bit, one-cycle pulse) SHALL assert with it.
REQ-023 Without it, WAIT_DONE SHALL wait indefinitely and no timeout port SHALL exist.

Structure
REQ-024 tx_packet codes, state enum, and max payload 64 SHALL live in shared package usb_pkg.
REQ-025 GAP and watchdog counting SHALL use one instance of sub-module flex_counter (clear, count_enable, rollover value).
REQ-026 Watchdog SHALL reuse the same flex_counter with rollover TIMEOUT_CYCLES in WAIT_DONE.

Verification
REQ-027 hs_req=1, hs_nak=0 -> tx_packet=2 for one cycle at clk 2, tx_done at clk 10 -> hs_done pulse at clk 11.
REQ-028 hs_req and data_req same cycle -> ACK/NAK issued first, DATA issued exactly IPG_CYCLES+2 clocks after hs tx_done.
REQ-029 data_req, data_size=5, five tx_get_packet pulses -> five data_pop pulses, tx_packet_data_size=5 through WAIT_DONE.
REQ-030 data_size=100 -> tx_packet_data_size=64.
REQ-031 n_rst low during WAIT_DONE -> all outputs 0 immediately, no done pulse, fresh request issues after 1 clock.
REQ-032 With USB_TX_ARB_TIMEOUT_EN and no tx_done -> timeout and data_done pulse after TIMEOUT_CYCLES, then GAP.
